// File: rtl/regbus_mem_responder.sv
// Regbus slave memory: byte-strobed words, programmable wait-state latency, error decode.
// Optional access counters are compiled in with `define REGBUS_MEM_ACCESS_CNT_EN.
module regbus_mem_responder #(
    parameter int unsigned           AddrWidth = 48,
    parameter int unsigned           DataWidth = 32,
    parameter int unsigned           NumWords  = 1024,
    parameter logic [AddrWidth-1:0]  BaseAddr  = '0,
    parameter int unsigned           Latency   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic                    req_write_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [DataWidth/8-1:0]  req_wstrb_i,
    output logic                    rsp_ready_o,
    output logic [DataWidth-1:0]    rsp_rdata_o,
    output logic                    rsp_error_o
`ifdef REGBUS_MEM_ACCESS_CNT_EN
    ,
    output logic [31:0]             rd_cnt_o,
    output logic [31:0]             wr_cnt_o,
    output logic [15:0]             err_cnt_o
`endif
);

    localparam int unsigned          IdxW    = $clog2(NumWords);
    localparam int unsigned          StrbW   = DataWidth / 8;
    localparam logic [AddrWidth:0]   EndAddr = {1'b0, BaseAddr} + ((AddrWidth+1)'(NumWords) << 2);
    localparam logic [7:0]           LatCnt  = 8'(Latency);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                 r_state;
    logic [7:0]             r_cnt;
    logic [AddrWidth-1:0]   r_addr;
    logic                   r_write;
    logic [DataWidth-1:0]   r_wdata;
    logic [StrbW-1:0]       r_wstrb;
    logic [DataWidth-1:0]   r_mem [NumWords];
    logic                   r_rsp_ready;
    logic [DataWidth-1:0]   r_rsp_rdata;
    logic                   r_rsp_error;

    logic [AddrWidth-1:0]   w_dec_addr;
    logic                   w_dec_write;
    logic                   w_in_range;
    logic                   w_aligned;
    logic                   w_err;
    logic [IdxW-1:0]        w_idx;

    // In IDLE the response may be loaded in the same edge as capture (Latency 0),
    // so decode the live request there and the captured one elsewhere.
    always_comb begin
        w_dec_addr  = (r_state == StIdle) ? req_addr_i  : r_addr;
        w_dec_write = (r_state == StIdle) ? req_write_i : r_write;
        w_in_range  = ({1'b0, w_dec_addr} >= {1'b0, BaseAddr}) && ({1'b0, w_dec_addr} < EndAddr);
        w_aligned   = (w_dec_addr[1:0] == 2'b00);
        w_err       = !w_in_range || !w_aligned;
        w_idx       = IdxW'((w_dec_addr - BaseAddr) >> 2);
    end

`ifdef REGBUS_MEM_ACCESS_CNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (r_state == StResp) begin
            if (w_err) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 16'd1;
            end else if (r_write) begin
                if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 32'd1;
            end else begin
                if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 32'd1;
            end
        end
    end

    assign rd_cnt_o  = r_rd_cnt;
    assign wr_cnt_o  = r_wr_cnt;
    assign err_cnt_o = r_err_cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_ready <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            for (int i = 0; i < NumWords; i++) r_mem[i] <= '0;
        end else begin
            r_rsp_ready <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (req_valid_i) begin
                        r_addr  <= req_addr_i;
                        r_write <= req_write_i;
                        r_wdata <= req_wdata_i;
                        r_wstrb <= req_wstrb_i;
                        r_cnt   <= LatCnt;
                        if (Latency == 0) begin
                            r_state     <= StResp;
                            r_rsp_ready <= 1'b1;
                            r_rsp_error <= w_err;
                            r_rsp_rdata <= (w_err || w_dec_write) ? '0 : r_mem[w_idx];
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!req_valid_i) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (r_cnt <= 8'd1) begin
                        r_state     <= StResp;
                        r_cnt       <= '0;
                        r_rsp_ready <= 1'b1;
                        r_rsp_error <= w_err;
                        r_rsp_rdata <= (w_err || w_dec_write) ? '0 : r_mem[w_idx];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                    if (r_write && !w_err) begin
                        for (int b = 0; b < StrbW; b++) begin
                            if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rsp_ready_o = r_rsp_ready;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_error_o = r_rsp_error;

endmodule

// File: tb/tb_regbus_mem_responder.sv
// Bench: two responders (Latency 2 at base 0, Latency 0 at base 0x1000) against a memory model.
module tb_regbus_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic [47:0] req_addr  [2];
    logic        req_write [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];
`ifdef REGBUS_MEM_ACCESS_CNT_EN
    logic [31:0] rd_cnt  [2];
    logic [31:0] wr_cnt  [2];
    logic [15:0] err_cnt [2];
`endif

    int n_checks;
    int n_fail;

    longint unsigned base   [2];
    int              nwords [2];
    int              lat    [2];
    logic [31:0]     model  [2][1024];
    bit              at_resp [2];
    int              exp_rd [2];
    int              exp_wr [2];
    int              exp_err [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regbus_mem_responder #(
        .AddrWidth (48),
        .DataWidth (32),
        .NumWords  (1024),
        .BaseAddr  (48'h0),
        .Latency   (2)
    ) u_dut_l2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid[0]),
        .req_addr_i  (req_addr[0]),
        .req_write_i (req_write[0]),
        .req_wdata_i (req_wdata[0]),
        .req_wstrb_i (req_wstrb[0]),
        .rsp_ready_o (rsp_ready[0]),
        .rsp_rdata_o (rsp_rdata[0]),
        .rsp_error_o (rsp_error[0])
`ifdef REGBUS_MEM_ACCESS_CNT_EN
        ,
        .rd_cnt_o    (rd_cnt[0]),
        .wr_cnt_o    (wr_cnt[0]),
        .err_cnt_o   (err_cnt[0])
`endif
    );

    regbus_mem_responder #(
        .AddrWidth (48),
        .DataWidth (32),
        .NumWords  (64),
        .BaseAddr  (48'h1000),
        .Latency   (0)
    ) u_dut_l0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid[1]),
        .req_addr_i  (req_addr[1]),
        .req_write_i (req_write[1]),
        .req_wdata_i (req_wdata[1]),
        .req_wstrb_i (req_wstrb[1]),
        .rsp_ready_o (rsp_ready[1]),
        .rsp_rdata_o (rsp_rdata[1]),
        .rsp_error_o (rsp_error[1])
`ifdef REGBUS_MEM_ACCESS_CNT_EN
        ,
        .rd_cnt_o    (rd_cnt[1]),
        .wr_cnt_o    (wr_cnt[1]),
        .err_cnt_o   (err_cnt[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) model[d][i] = 32'h0;
            exp_rd[d]  = 0;
            exp_wr[d]  = 0;
            exp_err[d] = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge inside the response cycle.
    task automatic access(input int d, input logic [47:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        longint unsigned a;
        bit              err;
        int              idx;
        logic [31:0]     exp_rdata;
        int              exp_k;
        int              cap_k;
        int              k;
        bit              got;
        a         = longint'(addr);
        err       = !(a >= base[d] && a < base[d] + longint'(nwords[d]) * 4) || (addr[1:0] != 2'b00);
        idx       = err ? 0 : int'((a - base[d]) / 4);
        exp_rdata = (err || wr) ? 32'h0 : model[d][idx];
        if (err) exp_err[d]++;
        else if (wr) exp_wr[d]++;
        else exp_rd[d]++;
        if (!err && wr) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        cap_k = at_resp[d] ? 2 : 1;
        exp_k = lat[d] + cap_k;
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_write[d] = wr;
        req_wdata[d] = wdata;
        req_wstrb[d] = wstrb;
        k   = 0;
        got = 1'b0;
        while (!got && k < exp_k + 4) begin
            @(negedge clk);
            k++;
            if (rsp_ready[d]) begin
                got = 1'b1;
            end else begin
                check_eq("quiet_outputs", {31'h0, rsp_error[d], rsp_rdata[d]}, 64'h0);
                // Once captured, payload wiggles must not affect the response.
                if (k >= cap_k) begin
                    req_addr[d]  = {16'h0, $urandom};
                    req_wdata[d] = $urandom;
                    req_wstrb[d] = 4'($urandom);
                    req_write[d] = 1'($urandom);
                end
            end
        end
        check_eq("ack_cycle", 64'(k), 64'(exp_k));
        check_eq("rsp_error", {63'h0, rsp_error[d]}, {63'h0, err});
        check_eq("rsp_rdata", {32'h0, rsp_rdata[d]}, {32'h0, exp_rdata});
        at_resp[d] = 1'b1;
    endtask

    task automatic idle(input int d, input int n);
        req_valid[d] = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_eq("no_ack", {63'h0, rsp_ready[d]}, 64'h0);
        end
        at_resp[d] = 1'b0;
    endtask

    initial begin
        logic [47:0] addr;
        int          cat;
        n_checks = 0;
        n_fail   = 0;
        base[0] = 64'h0;    nwords[0] = 1024; lat[0] = 2;
        base[1] = 64'h1000; nwords[1] = 64;   lat[1] = 0;
        clear_model();
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            req_write[d] = 1'b0;
            req_wdata[d] = '0;
            req_wstrb[d] = '0;
            at_resp[d]   = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_ready", {63'h0, rsp_ready[d]}, 64'h0);
            check_eq("reset_outs", {31'h0, rsp_error[d], rsp_rdata[d]}, 64'h0);
        end
        rst = 1'b0;
        idle(0, 2);

        // Full write, read back, partial write, error decode.
        access(0, 48'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
        idle(0, 1);
        access(0, 48'h10, 1'b0, 32'h0, 4'h0);
        idle(0, 1);
        access(0, 48'h10, 1'b1, 32'h1122_3344, 4'h5);
        idle(0, 1);
        access(0, 48'h10, 1'b0, 32'h0, 4'h0);
        check_eq("partial_value", {32'h0, rsp_rdata[0]}, 64'hDE22_BE44);
        idle(0, 1);
        access(0, 48'h1002, 1'b0, 32'h0, 4'h0);
        idle(0, 1);
        access(0, 48'h1000, 1'b1, 32'hFFFF_FFFF, 4'hF);
        idle(0, 1);
        access(0, 48'h0, 1'b0, 32'h0, 4'h0);
        idle(0, 2);

        // Abort: valid dropped in WAIT must not write.
        access(0, 48'h20, 1'b1, 32'hCAFE_F00D, 4'hF);
        idle(0, 1);
        req_valid[0] = 1'b1;
        req_addr[0]  = 48'h20;
        req_write[0] = 1'b1;
        req_wdata[0] = 32'h1234_5678;
        req_wstrb[0] = 4'hF;
        @(negedge clk);
        idle(0, 5);
        access(0, 48'h20, 1'b0, 32'h0, 4'h0);
        idle(0, 2);

        // Reset in the middle of a write.
        req_valid[0] = 1'b1;
        req_addr[0]  = 48'h30;
        req_write[0] = 1'b1;
        req_wdata[0] = 32'h5555_AAAA;
        req_wstrb[0] = 4'hF;
        @(negedge clk);
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("rst_no_ack", {63'h0, rsp_ready[0]}, 64'h0);
        rst = 1'b0;
        clear_model();
        idle(0, 3);
        access(0, 48'h30, 1'b0, 32'h0, 4'h0);
        idle(0, 1);
        access(0, 48'h10, 1'b0, 32'h0, 4'h0);
        idle(0, 2);

        // Latency 0: writes, then three back-to-back reads with valid held.
        idle(1, 1);
        for (int i = 0; i < 3; i++) begin
            access(1, 48'h1000 + 48'(i * 4), 1'b1, 32'hA0A0_0000 + 32'(i), 4'hF);
            idle(1, 1);
        end
        for (int i = 2; i >= 0; i--) access(1, 48'h1000 + 48'(i * 4), 1'b0, 32'h0, 4'h0);
        idle(1, 2);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                cat = int'($urandom_range(0, 9));
                if (cat == 0)
                    addr = 48'(base[d] + 64'($urandom_range(0, 7)) * 4 + 64'($urandom_range(1, 3)));
                else if (cat == 1)
                    addr = 48'(base[d] + 64'(nwords[d]) * 4 + 64'($urandom_range(0, 63)) * 4);
                else if (cat == 2)
                    addr = (base[d] != 0) ? 48'(base[d] - 64'($urandom_range(1, 16)) * 4)
                                          : 48'h8000_0000_0000;
                else
                    addr = 48'(base[d] + 64'($urandom_range(0, 7)) * 4);
                access(d, addr, 1'($urandom), $urandom, 4'($urandom));
                if ($urandom_range(0, 2) == 0) idle(d, int'($urandom_range(1, 3)));
            end
            idle(d, 2);
        end

`ifdef REGBUS_MEM_ACCESS_CNT_EN
        for (int d = 0; d < 2; d++) begin
            check_eq("rd_cnt", {32'h0, rd_cnt[d]}, 64'(exp_rd[d]));
            check_eq("wr_cnt", {32'h0, wr_cnt[d]}, 64'(exp_wr[d]));
            check_eq("err_cnt", {48'h0, err_cnt[d]}, 64'(exp_err[d]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
